id_scoreboard: RTL and testbench
================================

Name: id_scoreboard

Overview:
- Register-write scoreboard and issue controller between the decode stage and execute.
- Tracks every architectural register with a write in flight (issued, not yet written back by WB).
- Holds decode with a valid/ready handshake on RAW/WAW hazards or when the in-flight limit is reached.
- Clears on pipeline flush; keeps a saturating stall counter for performance monitoring.

Parameters:
- NREGS, 32, number of architectural registers (x0 hardwired zero)
- AW, 5, register address width (log2 NREGS)
- MAX_INFLIGHT, 4, max simultaneously pending register writes (1..NREGS-1)
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- i_id_valid  in  1  decode presents a valid instruction
- i_id_rs1_addr  in  AW  source register 1 address
- i_id_rs1_used  in  1  instruction reads rs1
- i_id_rs2_addr  in  AW  source register 2 address
- i_id_rs2_used  in  1  instruction reads rs2
- i_id_rd_addr  in  AW  destination register address
- i_id_rd_wr  in  1  instruction writes rd
- o_id_ready  out  1  instruction may issue this cycle (combinational)
- i_wb_wr_reg_en  in  1  WB writes the regfile this cycle
- i_wb_wr_reg_addr  in  AW  register being written by WB
- i_flush  in  1  squash all in-flight writes
- i_clr_cnt  in  1  clear stall counter
- o_busy_mask  out  NREGS  registered pending-write bitmap, bit i = xi pending
- o_inflight  out  AW+1  registered count of pending writes (= popcount of busy mask)
- o_stall_cnt  out  CNT_W  saturating count of stalled decode cycles

Behaviour:
- Reset (rst=1 at a clock edge): o_busy_mask=0, o_inflight=0, o_stall_cnt=0. o_id_ready is combinational and evaluates to 1 after reset, provided i_flush=0.
- Reset dominates flush, issue, retire and counter clear in the same cycle.
- Hazard terms (combinational), all using the registered o_busy_mask:
  - raw1 = i_id_rs1_used & rs1!=0 & busy[rs1]
  - raw2 = i_id_rs2_used & rs2!=0 & busy[rs2]
  - waw = i_id_rd_wr & rd!=0 & busy[rd]
  - full = i_id_rd_wr & rd!=0 & (o_inflight==MAX_INFLIGHT)
- o_id_ready = !(raw1 | raw2 | waw | full | i_flush). o_id_ready does not depend on i_id_valid.
- Issue fires when i_id_valid & o_id_ready.
  - If i_id_rd_wr & rd!=0: busy[rd] is set at the next edge and o_inflight increments.
  - Otherwise an issue has no state effect.
- Retire: i_wb_wr_reg_en & addr!=0 & busy[addr] clears busy[addr] at the next edge and decrements o_inflight.
  - A retire to x0 or to a non-pending register is ignored (covers writes from squashed instructions after a flush).
- No WB bypass: a register retiring in cycle N is still busy for hazard checks in cycle N. Issue of a dependent instruction is possible from cycle N+1.
- Simultaneous issue and retire:
  - Different registers: both applied; o_inflight unchanged.
  - Same register: impossible, since WAW blocks issue while the register is busy.
- At full, an instruction that does not write a register may still issue.
- Flush: i_flush=1 forces o_id_ready=0 that cycle. At the next edge busy mask and o_inflight become 0; retires in that cycle are discarded.
- Stall counter:
  - Increments by 1 each cycle with i_id_valid & !o_id_ready, including flush cycles.
  - Saturates at 2^CNT_W-1.
  - i_clr_cnt sets it to 0 and takes priority over increment.
- Invariant: o_inflight == popcount(o_busy_mask) <= MAX_INFLIGHT at all times. Check with an assertion.

Test Plan:
- Reset, then idle: o_busy_mask=0, o_inflight=0, o_stall_cnt=0; with valid, rs1=3 used, rd=5 write, o_id_ready=1.
- RAW stall and release:
  - Issue rd=5, then present rs1=5 used: o_id_ready=0, o_stall_cnt counts 1,2,3.
  - WB en with addr 5 in cycle N: ready still 0 in N, 1 in N+1, o_busy_mask=0x0000_0000.
- x0 handling: issue rd=0 write, then rs2=0 used: o_busy_mask stays 0, no stall; WB write to x0 leaves state unchanged.
- In-flight limit:
  - Issue rd=1,2,3,4 back-to-back: o_inflight=4, mask=0x1E.
  - rd=6 write: ready=0.
  - Non-writing instruction with rs1=7: ready=1.
  - Retire x2: next cycle inflight=3, rd=6 issues, mask=0x5A.
- Flush:
  - With mask=0x1E, assert i_flush together with WB addr 1: ready=0 that cycle, next cycle mask=0, inflight=0.
  - Later WB addr 3: ignored, inflight stays 0.
- Counter saturation with CNT_W=4: hold a stall 20 cycles -> o_stall_cnt=15. Then i_clr_cnt with stall still present -> 0, next cycle 1.

Source files
------------

// File: rtl/id_scoreboard.sv
// Register-write scoreboard between decode and execute: tracks pending writes,
// holds decode on RAW/WAW hazards or in-flight limit, and counts stalled cycles.
module id_scoreboard #(
  parameter int NREGS        = 32,
  parameter int AW           = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_valid,
  input  logic [AW-1:0]    i_id_rs1_addr,
  input  logic             i_id_rs1_used,
  input  logic [AW-1:0]    i_id_rs2_addr,
  input  logic             i_id_rs2_used,
  input  logic [AW-1:0]    i_id_rd_addr,
  input  logic             i_id_rd_wr,
  output logic             o_id_ready,
  input  logic             i_wb_wr_reg_en,
  input  logic [AW-1:0]    i_wb_wr_reg_addr,
  input  logic             i_flush,
  input  logic             i_clr_cnt,
  output logic [NREGS-1:0] o_busy_mask,
  output logic [AW:0]      o_inflight,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [AW:0]      INF_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]      INF_MAX  = (AW+1)'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NREGS-1:0] REG_ONE  = {{(NREGS-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]    X0       = {AW{1'b0}};

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic raw1_s, raw2_s, waw_s, full_s, ready_s;
  logic issue_wr_s, retire_s, stall_s;
  logic [NREGS-1:0] set_mask_s, clr_mask_s;

  // Hazard detection against the registered busy bitmap (no WB bypass).
  always_comb begin
    raw1_s  = i_id_rs1_used & (i_id_rs1_addr != X0) & busy_q[i_id_rs1_addr];
    raw2_s  = i_id_rs2_used & (i_id_rs2_addr != X0) & busy_q[i_id_rs2_addr];
    waw_s   = i_id_rd_wr & (i_id_rd_addr != X0) & busy_q[i_id_rd_addr];
    full_s  = i_id_rd_wr & (i_id_rd_addr != X0) & (inflight_q == INF_MAX);
    ready_s = ~(raw1_s | raw2_s | waw_s | full_s | i_flush);

    issue_wr_s = i_id_valid & ready_s & i_id_rd_wr & (i_id_rd_addr != X0);
    retire_s   = i_wb_wr_reg_en & (i_wb_wr_reg_addr != X0) & busy_q[i_wb_wr_reg_addr];
    stall_s    = i_id_valid & ~ready_s;

    set_mask_s = issue_wr_s ? (REG_ONE << i_id_rd_addr) : {NREGS{1'b0}};
    clr_mask_s = retire_s ? (REG_ONE << i_wb_wr_reg_addr) : {NREGS{1'b0}};
  end

  // Next-state for busy bitmap and in-flight count; flush discards everything.
  always_comb begin
    busy_d     = busy_q;
    inflight_d = inflight_q;
    if (i_flush) begin
      busy_d     = {NREGS{1'b0}};
      inflight_d = {(AW+1){1'b0}};
    end else begin
      busy_d = (busy_q & ~clr_mask_s) | set_mask_s;
      case ({issue_wr_s, retire_s})
        2'b10:   inflight_d = inflight_q + INF_ONE;
        2'b01:   inflight_d = inflight_q - INF_ONE;
        default: inflight_d = inflight_q;
      endcase
    end
  end

  // Saturating stall counter with clear priority.
  always_comb begin
    stall_d = stall_q;
    if (i_clr_cnt) begin
      stall_d = {CNT_W{1'b0}};
    end else if (stall_s && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= {NREGS{1'b0}};
      inflight_q <= {(AW+1){1'b0}};
      stall_q    <= {CNT_W{1'b0}};
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
    end
  end

  assign o_id_ready  = ready_s;
  assign o_busy_mask = busy_q;
  assign o_inflight  = inflight_q;
  assign o_stall_cnt = stall_q;

  id_scoreboard_chk #(
    .NREGS        (NREGS),
    .AW           (AW),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .busy_mask_i(busy_q),
    .inflight_i (inflight_q)
  );

endmodule

// Invariant checker: in-flight count equals popcount of busy bitmap and never exceeds the limit.
module id_scoreboard_chk #(
  parameter int NREGS        = 32,
  parameter int AW           = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input logic             clk,
  input logic             rst,
  input logic [NREGS-1:0] busy_mask_i,
  input logic [AW:0]      inflight_i
);

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] n;
    n = {(AW+1){1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      n = n + {{AW{1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Sample invariant once per cycle outside reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (inflight_i == popcount(busy_mask_i))
        else $error("inflight count disagrees with busy mask popcount");
      assert (inflight_i <= (AW+1)'(MAX_INFLIGHT))
        else $error("inflight count exceeds limit");
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed self-checking bench for id_scoreboard (stall counter narrowed to 4 bits).
module tb_id_scoreboard;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int MAXI  = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_id_valid;
  logic [AW-1:0]    i_id_rs1_addr;
  logic             i_id_rs1_used;
  logic [AW-1:0]    i_id_rs2_addr;
  logic             i_id_rs2_used;
  logic [AW-1:0]    i_id_rd_addr;
  logic             i_id_rd_wr;
  logic             o_id_ready;
  logic             i_wb_wr_reg_en;
  logic [AW-1:0]    i_wb_wr_reg_addr;
  logic             i_flush;
  logic             i_clr_cnt;
  logic [NREGS-1:0] o_busy_mask;
  logic [AW:0]      o_inflight;
  logic [CNT_W-1:0] o_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  id_scoreboard #(
    .NREGS(NREGS), .AW(AW), .MAX_INFLIGHT(MAXI), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .i_id_valid(i_id_valid),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs1_used(i_id_rs1_used),
    .i_id_rs2_addr(i_id_rs2_addr), .i_id_rs2_used(i_id_rs2_used),
    .i_id_rd_addr(i_id_rd_addr), .i_id_rd_wr(i_id_rd_wr),
    .o_id_ready(o_id_ready),
    .i_wb_wr_reg_en(i_wb_wr_reg_en), .i_wb_wr_reg_addr(i_wb_wr_reg_addr),
    .i_flush(i_flush), .i_clr_cnt(i_clr_cnt),
    .o_busy_mask(o_busy_mask), .o_inflight(o_inflight), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_id_valid = 1'b0; i_id_rs1_addr = 5'd0; i_id_rs1_used = 1'b0;
    i_id_rs2_addr = 5'd0; i_id_rs2_used = 1'b0; i_id_rd_addr = 5'd0;
    i_id_rd_wr = 1'b0; i_wb_wr_reg_en = 1'b0; i_wb_wr_reg_addr = 5'd0;
    i_flush = 1'b0; i_clr_cnt = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    i_id_valid = 1'b1; i_id_rd_addr = 5'd7; i_id_rd_wr = 1'b1; i_flush = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle();
    #1;
  endtask

  task automatic issue_wr(input logic [AW-1:0] rd);
    i_id_valid = 1'b1; i_id_rd_wr = 1'b1; i_id_rd_addr = rd;
    i_id_rs1_used = 1'b0; i_id_rs2_used = 1'b0;
    #1;
    n_cmp++;
    if (o_id_ready !== 1'b1) begin
      n_err++; $display("FAIL issue_ready rd=%0d got=%b exp=1", rd, o_id_ready);
    end
    step();
    i_id_valid = 1'b0; i_id_rd_wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (o_busy_mask !== 32'h0) begin n_err++; $display("FAIL rst_mask got=%h exp=0", o_busy_mask); end
    n_cmp++;
    if (o_inflight !== 6'd0) begin n_err++; $display("FAIL rst_inflight got=%0d exp=0", o_inflight); end
    n_cmp++;
    if (o_stall_cnt !== 4'd0) begin n_err++; $display("FAIL rst_stall got=%0d exp=0", o_stall_cnt); end
    i_id_valid = 1'b1; i_id_rs1_addr = 5'd3; i_id_rs1_used = 1'b1;
    i_id_rd_addr = 5'd5; i_id_rd_wr = 1'b1;
    #1;
    n_cmp++;
    if (o_id_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", o_id_ready); end
    idle();
  endtask

  task automatic test_raw();
    do_reset();
    issue_wr(5'd5);
    n_cmp++;
    if (o_busy_mask !== 32'h0000_0020) begin n_err++; $display("FAIL raw_mask got=%h exp=00000020", o_busy_mask); end
    i_id_valid = 1'b1; i_id_rs1_addr = 5'd5; i_id_rs1_used = 1'b1;
    #1;
    n_cmp++;
    if (o_id_ready !== 1'b0) begin n_err++; $display("FAIL raw_ready got=%b exp=0", o_id_ready); end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++;
      if (o_stall_cnt !== 4'(k)) begin n_err++; $display("FAIL raw_stall got=%0d exp=%0d", o_stall_cnt, k); end
    end
    i_wb_wr_reg_en = 1'b1; i_wb_wr_reg_addr = 5'd5;
    #1;
    n_cmp++;
    if (o_id_ready !== 1'b0) begin n_err++; $display("FAIL raw_nobypass got=%b exp=0", o_id_ready); end
    step();
    i_wb_wr_reg_en = 1'b0;
    #1;
    n_cmp++;
    if (o_id_ready !== 1'b1) begin n_err++; $display("FAIL raw_release got=%b exp=1", o_id_ready); end
    n_cmp++;
    if (o_busy_mask !== 32'h0) begin n_err++; $display("FAIL raw_mask_clr got=%h exp=0", o_busy_mask); end
    n_cmp++;
    if (o_stall_cnt !== 4'd4) begin n_err++; $display("FAIL raw_stall_final got=%0d exp=4", o_stall_cnt); end
    idle();
  endtask

  task automatic test_x0();
    do_reset();
    issue_wr(5'd0);
    n_cmp++;
    if (o_busy_mask !== 32'h0) begin n_err++; $display("FAIL x0_mask got=%h exp=0", o_busy_mask); end
    i_id_valid = 1'b1; i_id_rs2_addr = 5'd0; i_id_rs2_used = 1'b1;
    #1;
    n_cmp++;
    if (o_id_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got=%b exp=1", o_id_ready); end
    step();
    idle();
    issue_wr(5'd9);
    i_wb_wr_reg_en = 1'b1; i_wb_wr_reg_addr = 5'd0;
    step();
    i_wb_wr_reg_addr = 5'd7;
    step();
    i_wb_wr_reg_en = 1'b0;
    n_cmp++;
    if (o_busy_mask !== 32'h0000_0200) begin n_err++; $display("FAIL x0_wb_mask got=%h exp=00000200", o_busy_mask); end
    n_cmp++;
    if (o_inflight !== 6'd1) begin n_err++; $display("FAIL x0_wb_inflight got=%0d exp=1", o_inflight); end
    n_cmp++;
    if (o_stall_cnt !== 4'd0) begin n_err++; $display("FAIL x0_stall got=%0d exp=0", o_stall_cnt); end
  endtask

  task automatic test_limit();
    do_reset();
    for (int r = 1; r <= 4; r++) issue_wr(5'(r));
    n_cmp++;
    if (o_inflight !== 6'd4) begin n_err++; $display("FAIL lim_inflight got=%0d exp=4", o_inflight); end
    n_cmp++;
    if (o_busy_mask !== 32'h0000_001E) begin n_err++; $display("FAIL lim_mask got=%h exp=0000001e", o_busy_mask); end
    i_id_valid = 1'b1; i_id_rd_addr = 5'd6; i_id_rd_wr = 1'b1;
    #1;
    n_cmp++;
    if (o_id_ready !== 1'b0) begin n_err++; $display("FAIL lim_full got=%b exp=0", o_id_ready); end
    i_id_rd_addr = 5'd0;
    #1;
    n_cmp++;
    if (o_id_ready !== 1'b1) begin n_err++; $display("FAIL lim_full_x0 got=%b exp=1", o_id_ready); end
    i_id_rd_wr = 1'b0; i_id_rs1_addr = 5'd7; i_id_rs1_used = 1'b1;
    #1;
    n_cmp++;
    if (o_id_ready !== 1'b1) begin n_err++; $display("FAIL lim_nowrite got=%b exp=1", o_id_ready); end
    idle();
    i_wb_wr_reg_en = 1'b1; i_wb_wr_reg_addr = 5'd2;
    step();
    i_wb_wr_reg_en = 1'b0;
    n_cmp++;
    if (o_inflight !== 6'd3) begin n_err++; $display("FAIL lim_retire got=%0d exp=3", o_inflight); end
    issue_wr(5'd6);
    n_cmp++;
    if (o_busy_mask !== 32'h0000_005A) begin n_err++; $display("FAIL lim_mask2 got=%h exp=0000005a", o_busy_mask); end
    i_wb_wr_reg_en = 1'b1; i_wb_wr_reg_addr = 5'd4;
    step();
    i_wb_wr_reg_addr = 5'd1;
    issue_wr(5'd8);
    i_wb_wr_reg_en = 1'b0;
    n_cmp++;
    if (o_busy_mask !== 32'h0000_0148) begin n_err++; $display("FAIL lim_simul_mask got=%h exp=00000148", o_busy_mask); end
    n_cmp++;
    if (o_inflight !== 6'd3) begin n_err++; $display("FAIL lim_simul_inflight got=%0d exp=3", o_inflight); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int r = 1; r <= 4; r++) issue_wr(5'(r));
    i_id_valid = 1'b1; i_flush = 1'b1;
    i_wb_wr_reg_en = 1'b1; i_wb_wr_reg_addr = 5'd1;
    #1;
    n_cmp++;
    if (o_id_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready got=%b exp=0", o_id_ready); end
    step();
    idle();
    n_cmp++;
    if (o_busy_mask !== 32'h0) begin n_err++; $display("FAIL fl_mask got=%h exp=0", o_busy_mask); end
    n_cmp++;
    if (o_inflight !== 6'd0) begin n_err++; $display("FAIL fl_inflight got=%0d exp=0", o_inflight); end
    n_cmp++;
    if (o_stall_cnt !== 4'd1) begin n_err++; $display("FAIL fl_stall got=%0d exp=1", o_stall_cnt); end
    i_wb_wr_reg_en = 1'b1; i_wb_wr_reg_addr = 5'd3;
    step();
    i_wb_wr_reg_en = 1'b0;
    n_cmp++;
    if (o_inflight !== 6'd0) begin n_err++; $display("FAIL fl_late_wb got=%0d exp=0", o_inflight); end
  endtask

  task automatic test_saturation();
    do_reset();
    issue_wr(5'd5);
    i_id_valid = 1'b1; i_id_rs1_addr = 5'd5; i_id_rs1_used = 1'b1;
    for (int k = 0; k < 20; k++) step();
    n_cmp++;
    if (o_stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_cnt got=%0d exp=15", o_stall_cnt); end
    i_clr_cnt = 1'b1;
    step();
    i_clr_cnt = 1'b0;
    n_cmp++;
    if (o_stall_cnt !== 4'd0) begin n_err++; $display("FAIL sat_clr got=%0d exp=0", o_stall_cnt); end
    step();
    n_cmp++;
    if (o_stall_cnt !== 4'd1) begin n_err++; $display("FAIL sat_after_clr got=%0d exp=1", o_stall_cnt); end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_raw();
    test_x0();
    test_limit();
    test_flush();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
